// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
//
// Shared definitions for ready/valid stream blocks.
//   DEFAULT_DATA_WIDTH : default payload width of rv_if.
//   state_t            : occupancy state of a two-entry skid buffer.
//                        The encoding maps onto the two valid flops:
//                        bit 0 = main entry valid, bit 1 = skid entry valid.
//   main_valid/skid_valid : decode helpers for that encoding.
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    function automatic logic main_valid(input state_t s);
        return s[0];
    endfunction

    function automatic logic skid_valid(input state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/rv_if.sv
// ----------------------------------------------------------------------------
// rv_if
//
// Ready/valid stream interface.
//   clk   : system clock, rising edge active.
//   rst   : asynchronous reset, active-low.
//   valid : source has a beat.
//   ready : sink accepts a beat.
//   data  : payload, DataWidth bits.
// Modports:
//   source : drives valid/data, samples ready.
//   sink   : samples valid/data, drives ready.
// Built-in protocol checks flag a source that withdraws or alters a beat
// before it is accepted, and any X on the handshake or payload out of reset.
// ----------------------------------------------------------------------------
interface rv_if
    import rv_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH
) (
    input logic clk,
    input logic rst
);

    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data;

    modport source (
        input  clk,
        input  rst,
        input  ready,
        output valid,
        output data
    );

    modport sink (
        input  clk,
        input  rst,
        input  valid,
        input  data,
        output ready
    );

    // Once offered, a beat must stay on the bus unchanged until it is taken.
    property p_source_hold;
        @(posedge clk) disable iff (!rst)
            (valid && !ready) |=> (valid && $stable(data));
    endproperty

    // Handshake and payload must be fully defined whenever out of reset.
    property p_no_x;
        @(posedge clk) disable iff (!rst)
            !$isunknown({valid, ready, data});
    endproperty

    a_source_hold : assert property (p_source_hold);
    a_no_x        : assert property (p_no_x);

endinterface

// File: rtl/skid_buffer.sv
// ----------------------------------------------------------------------------
// skid_buffer
//
// Two-entry elastic stage on a ready/valid stream. Both directions are fully
// registered: rv_o.valid/rv_o.data come straight from the main entry flops,
// and rv_i.ready comes straight from a flop meaning "skid entry empty".
// Full throughput (one beat per cycle) with no loss, duplication or
// reordering.
//
// Ports:
//   rv_i : rv_if.sink   upstream stream; its clk/rst clock and reset
//                       this block (active-low, asynchronous).
//   rv_o : rv_if.source downstream stream, same clk/rst nets as rv_i.
// Payload width is taken from the connected interfaces.
// ----------------------------------------------------------------------------
module skid_buffer
    import rv_pkg::*;
(
    rv_if.sink   rv_i,
    rv_if.source rv_o
);

    localparam int DataWidth = $bits(rv_i.data);

    state_t               state_q;
    state_t               state_d;
    logic [DataWidth-1:0] main_data_q;
    logic [DataWidth-1:0] main_data_d;
    logic [DataWidth-1:0] skid_data_q;
    logic [DataWidth-1:0] skid_data_d;
    logic                 ready_q;
    logic                 ready_d;

    logic in_fire;
    logic out_fire;

    // Handshakes only ever look at registered local state on our side, so
    // neither output depends combinationally on the opposite port.
    assign in_fire  = rv_i.valid && ready_q;
    assign out_fire = main_valid(state_q) && rv_o.ready;

    // State register: occupancy, both payload entries and the upstream
    // ready flop. Everything clears on reset so stored beats are discarded.
    always_ff @(posedge rv_i.clk or negedge rv_i.rst) begin
        if (!rv_i.rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic. Data registers hold unless written, so the payload
    // seen on rv_o stays at its last value while rv_o.valid is low.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = rv_i.data;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    // Pass-through: occupancy unchanged, no bubble.
                    main_data_d = rv_i.data;
                end else if (in_fire) begin
                    // Downstream stalled while we were still accepting:
                    // the beat already in flight lands in the skid entry.
                    skid_data_d = rv_i.data;
                    state_d     = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // rv_i.ready is low here, so only draining can happen.
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    state_d     = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Upstream may send whenever the skid entry will be empty.
        ready_d = !skid_valid(state_d);
    end

    // Outputs: all taken directly from flops.
    always_comb begin
        rv_o.valid = main_valid(state_q);
        rv_o.data  = main_data_q;
        rv_i.ready = ready_q;
    end

endmodule

// File: tb/tb_skid_buffer.sv
// ----------------------------------------------------------------------------
// tb_skid_buffer
//
// Self-checking bench for skid_buffer: a directed vector table (reset, single
// beat, streaming), hand-written stall and reset-in-FULL sequences, and a
// randomised stream checked against an in-order scoreboard and an occupancy
// model.
// ----------------------------------------------------------------------------
module tb_skid_buffer;

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ready;
    } vec_t;

    logic clk;
    logic rst_n;

    int num_checks;
    int num_fails;

    vec_t vecs[$];

    rv_if #(.DataWidth(8)) up_if (.clk(clk), .rst(rst_n));
    rv_if #(.DataWidth(8)) dn_if (.clk(clk), .rst(rst_n));

    skid_buffer dut (
        .rv_i(up_if),
        .rv_o(dn_if)
    );

    // Free-running clock, 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive upstream beat and downstream ready.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        up_if.valid = v;
        up_if.data  = d;
        dn_if.ready = r;
    endtask

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Check all three registered outputs against expected values.
    task automatic checkAll(input string name, input logic ev, input logic [7:0] ed,
                            input logic er);
        checkOutput({name, " out_valid"}, 32'(dn_if.valid), 32'(ev));
        checkOutput({name, " out_data"}, 32'(dn_if.data), 32'(ed));
        checkOutput({name, " in_ready"}, 32'(up_if.ready), 32'(er));
    endtask

    task automatic addVec(input logic v, input logic [7:0] d, input logic r,
                          input logic ev, input logic [7:0] ed, input logic er);
        vec_t x;
        x.in_valid  = v;
        x.in_data   = d;
        x.out_ready = r;
        x.exp_valid = ev;
        x.exp_data  = ed;
        x.exp_ready = er;
        vecs.push_back(x);
    endtask

    initial begin
        logic [7:0] sb_q[$];
        logic [7:0] cur_data;
        logic [7:0] exp_d;
        logic       cur_valid;
        logic       up_fire;
        logic       dn_fire;
        int         occ;
        int         sent;
        int         recv;
        int         cycles;
        int         stale;

        num_checks = 0;
        num_fails  = 0;

        // Vector table: expected outputs are those seen before the inputs
        // of the same row are applied (outputs are registered).
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        addVec(1'b1, 8'hFA, 1'b1, 1'b0, 8'h00, 1'b1);
        addVec(1'b0, 8'h00, 1'b1, 1'b1, 8'hFA, 1'b1);
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 8'hFA, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            addVec(1'b1, 8'(k), 1'b1, (k != 1), (k == 1) ? 8'hFA : 8'(k - 1), 1'b1);
        end
        addVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 1'b1);
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 8'h0A, 1'b1);

        // Reset: asserted with a clean edge, held about 20 ns.
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #11;
        checkAll("reset", 1'b0, 8'h00, 1'b1);
        #10 rst_n = 1'b1;

        // Directed table: idle, single beat, streaming.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                     vecs[i].exp_ready);
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
        end

        // Stall: 0x11 is caught by the skid while 0x10 is stuck on the output.
        @(negedge clk);
        applyStimulus(1'b1, 8'h10, 1'b1);
        @(negedge clk);
        checkAll("stall_a", 1'b1, 8'h10, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b0);
        @(negedge clk);
        checkAll("stall_b", 1'b1, 8'h10, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b0);
        @(negedge clk);
        checkAll("stall_c", 1'b1, 8'h10, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b1);
        @(negedge clk);
        checkAll("stall_d", 1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h12, 1'b1);
        @(negedge clk);
        checkAll("stall_e", 1'b1, 8'h12, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkAll("stall_f", 1'b0, 8'h12, 1'b1);

        // Reset while FULL: both entries occupied, then reset.
        applyStimulus(1'b1, 8'hA1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        @(negedge clk);
        checkAll("full", 1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkAll("rst_full", 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dn_if.valid) stale++;
        end
        checkOutput("no_stale_beat", 32'(stale), 32'd0);

        // Random stream with scoreboard and occupancy model.
        occ       = 0;
        sent      = 0;
        recv      = 0;
        cycles    = 0;
        cur_valid = 1'b0;
        cur_data  = 8'h00;
        up_fire   = 1'b0;
        while (recv < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (up_fire) cur_valid = 1'b0;
            if (!cur_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                cur_valid = 1'b1;
                cur_data  = 8'($urandom);
            end
            applyStimulus(cur_valid, cur_data, 1'($urandom_range(0, 1)));
            #3;
            if (dn_if.valid !== (occ > 0)) begin
                checkOutput("rand out_valid", 32'(dn_if.valid), 32'(occ > 0));
            end
            if (up_if.ready !== (occ < 2)) begin
                checkOutput("rand in_ready", 32'(up_if.ready), 32'(occ < 2));
            end
            up_fire = up_if.valid && up_if.ready;
            dn_fire = dn_if.valid && dn_if.ready;
            if (dn_fire) begin
                exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                checkOutput($sformatf("rand beat%0d", recv), 32'(dn_if.data), 32'(exp_d));
                recv++;
                occ--;
            end
            if (up_fire) begin
                sb_q.push_back(cur_data);
                sent++;
                occ++;
            end
        end
        checkOutput("rand beats received", 32'(recv), 32'd1000);
        checkOutput("rand beats sent", 32'(sent), 32'd1000);

        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
